// File: rtl/mii_frame_gen.sv
// MAC-to-PCS transmit beat generator: wraps valid/ready frame beats in an XGMII-style
// lane-0-aligned start/preamble/terminate sequence, enforcing a minimum inter-packet gap.
module mii_frame_gen #(
  parameter int LANES   = 8,
  parameter int IPG_MIN = 12
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [8*LANES-1:0]   i_data,
  input  logic [LANES-1:0]     i_keep,
  input  logic                 i_last,
  input  logic                 i_err,
  output logic [8*LANES-1:0]   o_mii_txd,
  output logic [LANES-1:0]     o_mii_txc,
  output logic [31:0]          o_frames_sent,
  output logic [15:0]          o_frames_aborted
);

  localparam int          PRE_BEATS = 8 / LANES;
  localparam logic [3:0]  PRE_LAST  = 4'(PRE_BEATS - 1);
  localparam logic [15:0] IPG_MAX   = 16'(IPG_MIN);
  localparam logic [15:0] LANES16   = 16'(LANES);

  localparam logic [7:0] C_IDLE  = 8'h07;
  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_ERR   = 8'hFE;
  localparam logic [7:0] C_PRE   = 8'h55;
  localparam logic [7:0] C_SFD   = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA  = 3'd2,
    ST_TERM  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t               state_q;
  logic [3:0]           pre_q;
  logic                 bad_q;
  logic                 ready_q;
  logic [15:0]          ipg_q;
  logic [8*LANES-1:0]   txd_q;
  logic [LANES-1:0]     txc_q;
  logic [31:0]          sent_q;
  logic [15:0]          aborted_q;

  logic [15:0]          keep_cnt;
  logic [15:0]          ipg_sum;
  logic [15:0]          ipg_add_d;
  logic                 ipg_ok;
  logic [8*LANES-1:0]   data_txd_d;
  logic [LANES-1:0]     data_txc_d;

  // Preamble beat idx covers bytes idx*LANES .. idx*LANES+LANES-1 of FB 55x6 D5.
  function automatic logic [8*LANES-1:0] pre_txd(input logic [3:0] idx);
    logic [8*LANES-1:0] t;
    int b;
    t = '0;
    for (int l = 0; l < LANES; l++) begin
      b = int'(idx) * LANES + l;
      t[8*l +: 8] = (b == 0) ? C_START : ((b == 7) ? C_SFD : C_PRE);
    end
    return t;
  endfunction

  function automatic logic [LANES-1:0] pre_txc(input logic [3:0] idx);
    logic [LANES-1:0] t;
    t = '0;
    t[0] = (idx == 4'd0);
    return t;
  endfunction

  always_comb begin
    keep_cnt = '0;
    for (int l = 0; l < LANES; l++) keep_cnt = keep_cnt + 16'(i_keep[l]);
  end

  assign ipg_sum   = ipg_q + LANES16;
  assign ipg_add_d = (ipg_sum >= IPG_MAX) ? IPG_MAX : ipg_sum;
  assign ipg_ok    = (ipg_q >= IPG_MAX);

  // Lanes past the terminate are idle fill; error marking leaves terminate placement alone.
  always_comb begin
    data_txd_d = i_data;
    data_txc_d = '0;
    for (int l = 0; l < LANES; l++) begin
      if (i_last && (16'(l) > keep_cnt)) begin
        data_txd_d[8*l +: 8] = C_IDLE;
        data_txc_d[l]        = 1'b1;
      end else if (i_last && (16'(l) == keep_cnt)) begin
        data_txd_d[8*l +: 8] = C_TERM;
        data_txc_d[l]        = 1'b1;
      end else if (i_err) begin
        data_txd_d[8*l +: 8] = C_ERR;
        data_txc_d[l]        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      pre_q     <= '0;
      bad_q     <= 1'b0;
      ready_q   <= 1'b0;
      ipg_q     <= IPG_MAX;
      txd_q     <= {LANES{C_IDLE}};
      txc_q     <= '1;
      sent_q    <= '0;
      aborted_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid && ipg_ok) begin
            txd_q <= pre_txd(4'd0);
            txc_q <= pre_txc(4'd0);
            bad_q <= 1'b0;
            pre_q <= 4'd1;
            if (PRE_LAST == 4'd0) begin
              state_q <= ST_DATA;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_PRE;
            end
          end else begin
            txd_q <= {LANES{C_IDLE}};
            txc_q <= '1;
            ipg_q <= ipg_add_d;
          end
        end
        ST_PRE: begin
          txd_q <= pre_txd(pre_q);
          txc_q <= pre_txc(pre_q);
          if (pre_q == PRE_LAST) begin
            state_q <= ST_DATA;
            ready_q <= 1'b1;
          end else begin
            pre_q <= pre_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (i_valid) begin
            txd_q <= data_txd_d;
            txc_q <= data_txc_d;
            if (i_last) begin
              ready_q <= 1'b0;
              if (bad_q || i_err) aborted_q <= aborted_q + 16'd1;
              else                sent_q    <= sent_q + 32'd1;
              if (keep_cnt < LANES16) begin
                state_q <= ST_IDLE;
                ipg_q   <= LANES16 - keep_cnt - 16'd1;
              end else begin
                state_q <= ST_TERM;
              end
            end else if (i_err) begin
              bad_q <= 1'b1;
            end
          end else begin
            // Underrun: poison the frame, then swallow the rest of it in DRAIN.
            txd_q     <= {LANES{C_ERR}};
            txc_q     <= '1;
            ipg_q     <= '0;
            aborted_q <= aborted_q + 16'd1;
            state_q   <= ST_DRAIN;
          end
        end
        ST_TERM: begin
          txd_q   <= {{(LANES-1){C_IDLE}}, C_TERM};
          txc_q   <= '1;
          ipg_q   <= LANES16 - 16'd1;
          state_q <= ST_IDLE;
        end
        ST_DRAIN: begin
          txd_q <= {LANES{C_IDLE}};
          txc_q <= '1;
          ipg_q <= ipg_add_d;
          if (i_valid && i_last) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          txd_q   <= {LANES{C_IDLE}};
          txc_q   <= '1;
        end
      endcase
    end
  end

  assign o_ready          = ready_q;
  assign o_mii_txd        = txd_q;
  assign o_mii_txc        = txc_q;
  assign o_frames_sent    = sent_q;
  assign o_frames_aborted = aborted_q;

endmodule

// File: tb/tb_mii_frame_gen.sv
// Directed bench for mii_frame_gen: an 8-lane and a 4-lane instance driven in turn.
module tb_mii_frame_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v8, l8, e8, r8;
  logic [63:0] d8, txd8;
  logic [7:0]  k8, txc8;
  logic [31:0] s8;
  logic [15:0] a8;

  logic        v4, l4, e4, r4;
  logic [31:0] d4, txd4;
  logic [3:0]  k4, txc4;
  logic [31:0] s4;
  logic [15:0] a4;

  int vecs = 0;
  int errs = 0;

  localparam logic [63:0] IDLE8 = 64'h0707070707070707;
  localparam logic [63:0] FE8   = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] PRE8  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM8 = 64'h07070707070707FD;
  localparam logic [31:0] IDLE4 = 32'h07070707;

  mii_frame_gen #(.LANES(8), .IPG_MIN(12)) u8 (
    .clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(r8), .i_data(d8),
    .i_keep(k8), .i_last(l8), .i_err(e8), .o_mii_txd(txd8), .o_mii_txc(txc8),
    .o_frames_sent(s8), .o_frames_aborted(a8)
  );

  mii_frame_gen #(.LANES(4), .IPG_MIN(12)) u4 (
    .clk(clk), .i_rst_n(rst_n), .i_valid(v4), .o_ready(r4), .i_data(d4),
    .i_keep(k4), .i_last(l4), .i_err(e4), .o_mii_txd(txd4), .o_mii_txc(txc4),
    .o_frames_sent(s4), .o_frames_aborted(a4)
  );

  function automatic logic [63:0] beat8(input logic [7:0] b);
    logic [63:0] r;
    for (int l = 0; l < 8; l++) r[8*l +: 8] = b + 8'(l);
    return r;
  endfunction

  function automatic logic [31:0] beat4(input logic [7:0] b);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = b + 8'(l);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [63:0] txd, input logic [7:0] txc);
    chk({tag, ".txd"}, txd8, txd);
    chk({tag, ".txc"}, 64'(txc8), 64'(txc));
  endtask

  task automatic chk4(input string tag, input logic [31:0] txd, input logic [3:0] txc);
    chk({tag, ".txd"}, 64'(txd4), 64'(txd));
    chk({tag, ".txc"}, 64'(txc4), 64'(txc));
  endtask

  logic [63:0] exp8;
  logic [31:0] exp4;

  initial begin
    v8 = 1'b1; d8 = beat8(8'h00); k8 = 8'hFF; l8 = 1'b0; e8 = 1'b0;
    v4 = 1'b0; d4 = '0; k4 = 4'hF; l4 = 1'b0; e4 = 1'b0;
    #12;
    chk8("rst8", IDLE8, 8'hFF);
    chk("rst8.ready", 64'(r8), 64'd0);
    chk("rst8.sent", 64'(s8), 64'd0);
    chk("rst8.abort", 64'(a8), 64'd0);
    chk4("rst4", IDLE4, 4'hF);
    rst_n = 1'b1;

    // Frame A: 64 bytes, valid already waiting at reset release
    tick();
    chk8("A.pre", PRE8, 8'h01);
    chk("A.ready", 64'(r8), 64'd1);
    for (int i = 0; i < 8; i++) begin
      d8 = beat8(8'(8*i)); l8 = (i == 7);
      tick();
      chk8("A.data", beat8(8'(8*i)), 8'h00);
    end
    chk("A.ready_off", 64'(r8), 64'd0);
    l8 = 1'b0; d8 = beat8(8'h80);
    tick();
    chk8("A.term", TERM8, 8'hFF);
    chk("A.sent", 64'(s8), 64'd1);
    tick();
    chk8("A.gap", IDLE8, 8'hFF);
    tick();
    chk8("B.pre", PRE8, 8'h01);

    // Frame B: 61 bytes, last beat keeps 5 lanes
    for (int i = 0; i < 8; i++) begin
      d8 = beat8(8'(8'h80 + 8*i)); l8 = (i == 7); k8 = (i == 7) ? 8'h1F : 8'hFF;
      tick();
      if (i < 7) chk8("B.data", beat8(8'(8'h80 + 8*i)), 8'h00);
    end
    exp8 = beat8(8'hB8);
    exp8[63:40] = 24'h0707FD;
    chk8("B.last", exp8, 8'hE0);
    chk("B.sent", 64'(s8), 64'd2);
    k8 = 8'hFF; l8 = 1'b0;
    tick();
    chk8("B.gap1", IDLE8, 8'hFF);
    tick();
    chk8("B.gap2", IDLE8, 8'hFF);
    tick();
    chk8("C.pre", PRE8, 8'h01);

    // Frame C: error on the third beat
    for (int i = 0; i < 8; i++) begin
      d8 = beat8(8'(8'h10 + 8*i)); l8 = (i == 7); e8 = (i == 2);
      tick();
      if (i == 2) chk8("C.err", FE8, 8'hFF);
      else        chk8("C.data", beat8(8'(8'h10 + 8*i)), 8'h00);
    end
    e8 = 1'b0; l8 = 1'b0;
    tick();
    chk8("C.term", TERM8, 8'hFF);
    chk("C.sent", 64'(s8), 64'd2);
    chk("C.abort", 64'(a8), 64'd1);
    tick();
    chk8("C.gap", IDLE8, 8'hFF);
    tick();
    chk8("D.pre", PRE8, 8'h01);

    // Frame D: underrun after seven beats, last beat then drained
    for (int i = 0; i < 7; i++) begin
      d8 = beat8(8'(8'hA0 + 8*i));
      tick();
      chk8("D.data", beat8(8'(8'hA0 + 8*i)), 8'h00);
    end
    v8 = 1'b0;
    tick();
    chk8("D.under", FE8, 8'hFF);
    chk("D.abort", 64'(a8), 64'd2);
    chk("D.ready", 64'(r8), 64'd1);
    v8 = 1'b1; l8 = 1'b1; d8 = beat8(8'hD8);
    tick();
    chk8("D.drain", IDLE8, 8'hFF);
    chk("D.ready_off", 64'(r8), 64'd0);
    l8 = 1'b0;
    tick();
    chk8("D.gap", IDLE8, 8'hFF);
    chk("D.sent", 64'(s8), 64'd2);
    tick();
    chk8("E.pre", PRE8, 8'h01);

    // Frame E: reset asserted mid-frame
    for (int i = 0; i < 2; i++) begin
      d8 = beat8(8'(8'h30 + 8*i));
      tick();
      chk8("E.data", beat8(8'(8'h30 + 8*i)), 8'h00);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk8("E.rst", IDLE8, 8'hFF);
    chk("E.rst.ready", 64'(r8), 64'd0);
    chk("E.rst.sent", 64'(s8), 64'd0);
    chk("E.rst.abort", 64'(a8), 64'd0);
    rst_n = 1'b1;
    tick();
    chk8("E.repre", PRE8, 8'h01);
    v8 = 1'b0;

    // 4-lane instance: two-beat preamble and IPG between back-to-back frames
    v4 = 1'b1; k4 = 4'hF; d4 = beat4(8'h00);
    tick();
    chk4("F.pre0", 32'h555555FB, 4'h1);
    chk("F.pre0.ready", 64'(r4), 64'd0);
    tick();
    chk4("F.pre1", 32'hD5555555, 4'h0);
    chk("F.ready", 64'(r4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      d4 = beat4(8'(4*i)); l4 = (i == 3);
      tick();
      chk4("F.data", beat4(8'(4*i)), 4'h0);
    end
    l4 = 1'b0;
    tick();
    chk4("F.term", 32'h070707FD, 4'hF);
    chk("F.sent", 64'(s4), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("F.gap", IDLE4, 4'hF);
    end
    tick();
    chk4("G.pre0", 32'h555555FB, 4'h1);
    tick();
    chk4("G.pre1", 32'hD5555555, 4'h0);
    for (int i = 0; i < 3; i++) begin
      d4 = beat4(8'(8'h50 + 4*i)); l4 = (i == 2); k4 = (i == 2) ? 4'h7 : 4'hF;
      tick();
      if (i < 2) chk4("G.data", beat4(8'(8'h50 + 4*i)), 4'h0);
    end
    exp4 = beat4(8'h58);
    exp4[31:24] = 8'hFD;
    chk4("G.last", exp4, 4'h8);
    chk("G.sent", 64'(s4), 64'd2);
    chk("G.abort", 64'(a4), 64'd0);
    l4 = 1'b0; k4 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("G.gap", IDLE4, 4'hF);
    end
    tick();
    chk4("H.pre0", 32'h555555FB, 4'h1);
    v4 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
